// File: rtl/fm_i2s_tx.sv
// Stereo I2S transmitter: buffers L/R sample pairs in a small FIFO and serialises
// each pair into a 2*SLOT_WIDTH-bit I2S frame. Optional macro FM_I2S_HOLD_LAST_EN.
module fm_i2s_tx #(
    parameter int DATA_WIDTH = 10,
    parameter int SLOT_WIDTH = 16,
    parameter int SCLK_DIV   = 8,
    parameter int FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_right,
    input  logic                  in_valid,
    output logic                  i2s_bclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdata,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = $clog2(SCLK_DIV);
    localparam int DEPTH      = 1 << FIFO_AW;
    localparam int CNT_W      = FIFO_AW + 1;

    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [BIT_W-1:0]        next_bit;
    logic [SLOT_WIDTH-1:0]   slot_left;
    logic [SLOT_WIDTH-1:0]   slot_right;
    logic [SLOT_WIDTH-1:0]   frame_left;
    logic [SLOT_WIDTH-1:0]   frame_right;
    logic [FRAME_BITS-1:0]   frame_word;
    logic [2*DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr;
    logic [FIFO_AW-1:0]      rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    div_tc;
    logic                    fall_event;
    logic                    frame_start;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic                    sdata_next;
    logic                    lrck_next;

    // Samples are left-justified in the slot with zero padding below the LSB.
    function automatic logic [SLOT_WIDTH-1:0] to_slot(input logic [DATA_WIDTH-1:0] s);
        logic [SLOT_WIDTH-1:0] w;
        w = '0;
        w[SLOT_WIDTH-1 -: DATA_WIDTH] = s;
        return w;
    endfunction

    assign div_tc      = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign fall_event  = div_tc && i2s_bclk;
    assign next_bit    = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
    assign frame_start = fall_event && (next_bit == '0);
    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CNT_W'(DEPTH));
    assign pop         = frame_start && !fifo_empty;
    assign push        = in_valid && (!fifo_full || pop);
    assign drop        = in_valid && fifo_full && !pop;

    // At frame start the freshly loaded pair must already feed the MSB of this update.
    always_comb begin
        frame_left  = slot_left;
        frame_right = slot_right;
        if (frame_start) begin
            if (pop) begin
                frame_left  = to_slot(mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH]);
                frame_right = to_slot(mem[rd_ptr][DATA_WIDTH-1:0]);
            end else begin
`ifdef FM_I2S_HOLD_LAST_EN
                frame_left  = slot_left;
                frame_right = slot_right;
`else
                frame_left  = '0;
                frame_right = '0;
`endif
            end
        end
        frame_word = {frame_left, frame_right};
        sdata_next = frame_word[BIT_W'(FRAME_BITS - 1) - next_bit];
        lrck_next  = (next_bit >= BIT_W'(SLOT_WIDTH - 1)) && (next_bit <= BIT_W'(FRAME_BITS - 2));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            bit_cnt    <= BIT_W'(FRAME_BITS - 1);
            i2s_bclk   <= 1'b0;
            i2s_lrck   <= 1'b0;
            i2s_sdata  <= 1'b0;
            slot_left  <= '0;
            slot_right <= '0;
            underflow  <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            div_cnt   <= div_tc ? '0 : div_cnt + DIV_W'(1);
            underflow <= frame_start && fifo_empty;
            if (div_tc) begin
                i2s_bclk <= ~i2s_bclk;
            end
            if (fall_event) begin
                bit_cnt    <= next_bit;
                i2s_sdata  <= sdata_next;
                i2s_lrck   <= lrck_next;
                slot_left  <= frame_left;
                slot_right <= frame_right;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= {in_left, in_right};
        end
    end

endmodule

// File: tb/tb_fm_i2s_tx.sv
// Self-checking bench for fm_i2s_tx with SCLK_DIV=2: frames are captured from the
// serial pins at known clk offsets and compared with hand-computed slot words.
module tb_fm_i2s_tx;

    typedef struct {
        logic [9:0]  left;
        logic [9:0]  right;
        logic [15:0] expLeft;
        logic [15:0] expRight;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] inLeft = '0;
    logic [9:0] inRight = '0;
    logic       inValid = 1'b0;
    logic       i2sBclk;
    logic       i2sLrck;
    logic       i2sSdata;
    logic       fifoFull;
    logic       overflow;
    logic       underflow;

    int compared = 0;
    int mismatched = 0;
    int bclkErr = 0;
    int n = 0;

    vec_t vectors [4];
    vec_t fills [5];

    fm_i2s_tx #(
        .DATA_WIDTH(10),
        .SLOT_WIDTH(16),
        .SCLK_DIV  (2),
        .FIFO_AW   (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_left  (inLeft),
        .in_right (inRight),
        .in_valid (inValid),
        .i2s_bclk (i2sBclk),
        .i2s_lrck (i2sLrck),
        .i2s_sdata(i2sSdata),
        .fifo_full(fifoFull),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One clk edge; n counts edges since reset release and bclk is checked against n.
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        if (i2sBclk !== ((n % 4) >= 2)) bclkErr++;
    endtask

    task automatic doReset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        n = 0;
    endtask

    // Frames start on the fall events at edges 4, 132, 260, ...
    function automatic int nextStart(input int now);
        if (now <= 4) return 4;
        return 4 + 128 * ((now - 4 + 127) / 128);
    endfunction

    task automatic applyStimulus(input logic [9:0] l, input logic [9:0] r);
        inLeft  = l;
        inRight = r;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
    endtask

    // ufPattern bit0 = underflow at frame start, bit1 = underflow seen anywhere else.
    task automatic captureFrame(output logic [31:0] data, output logic [31:0] ws, output int ufPattern);
        int f;
        int ufOther;
        f = nextStart(n);
        while (n < f) tick();
        data = '0;
        ws = '0;
        ufOther = 0;
        ufPattern = (underflow === 1'b1) ? 1 : 0;
        for (int b = 0; b < 32; b++) begin
            if (b > 0) begin
                repeat (4) begin
                    tick();
                    if (underflow !== 1'b0) ufOther++;
                end
            end
            data[31-b] = i2sSdata;
            ws[31-b]   = i2sLrck;
        end
        if (ufOther != 0) ufPattern = ufPattern + 2;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_bclk"}, {31'd0, i2sBclk}, 32'd0);
        checkOutput({tag, "_lrck"}, {31'd0, i2sLrck}, 32'd0);
        checkOutput({tag, "_sdata"}, {31'd0, i2sSdata}, 32'd0);
        checkOutput({tag, "_underflow"}, {31'd0, underflow}, 32'd0);
        checkOutput({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        checkOutput({tag, "_fifo_full"}, {31'd0, fifoFull}, 32'd0);
    endtask

    initial begin
        logic [31:0] data;
        logic [31:0] ws;
        logic [31:0] holdExp;
        int uf;
        int target;

        vectors[0] = '{10'h3FF, 10'h000, 16'hFFC0, 16'h0000};
        vectors[1] = '{10'h200, 10'h1FF, 16'h8000, 16'h7FC0};
        vectors[2] = '{10'h001, 10'h3FE, 16'h0040, 16'hFF80};
        vectors[3] = '{10'h155, 10'h2AA, 16'h5540, 16'hAA80};

        fills[0] = '{10'h001, 10'h002, 16'h0040, 16'h0080};
        fills[1] = '{10'h004, 10'h008, 16'h0100, 16'h0200};
        fills[2] = '{10'h010, 10'h020, 16'h0400, 16'h0800};
        fills[3] = '{10'h040, 10'h080, 16'h1000, 16'h2000};
        fills[4] = '{10'h100, 10'h200, 16'h4000, 16'h8000};

        doReset(2);
        checkResetState("reset");

        // Idle: zero frame, standard LRCK pattern, one underflow at the frame start.
        captureFrame(data, ws, uf);
        checkOutput("idle_data", data, 32'h0);
        checkOutput("idle_lrck", ws, 32'h0001_FFFE);
        checkOutput("idle_underflow", uf, 32'd1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i].left, vectors[i].right);
            captureFrame(data, ws, uf);
            checkOutput($sformatf("vec%0d_data", i), data, {vectors[i].expLeft, vectors[i].expRight});
            checkOutput($sformatf("vec%0d_lrck", i), ws, 32'h0001_FFFE);
            checkOutput($sformatf("vec%0d_underflow", i), uf, 32'd0);
        end

`ifdef FM_I2S_HOLD_LAST_EN
        holdExp = 32'h5540_AA80;
`else
        holdExp = 32'h0;
`endif
        captureFrame(data, ws, uf);
        checkOutput("starve_data", data, holdExp);
        checkOutput("starve_underflow", uf, 32'd1);

        // Fill the FIFO, then push again on the exact pop edge.
        target = nextStart(n) + 1;
        while (n < target) tick();
        for (int i = 0; i < 4; i++) applyStimulus(fills[i].left, fills[i].right);
        checkOutput("fill_full", {31'd0, fifoFull}, 32'd1);
        checkOutput("fill_overflow", {31'd0, overflow}, 32'd0);
        target = nextStart(n) - 1;
        while (n < target) tick();
        applyStimulus(fills[4].left, fills[4].right);
        checkOutput("poppush_full", {31'd0, fifoFull}, 32'd1);
        checkOutput("poppush_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            captureFrame(data, ws, uf);
            checkOutput($sformatf("fill%0d_data", i), data, {fills[i].expLeft, fills[i].expRight});
            checkOutput($sformatf("fill%0d_underflow", i), uf, 32'd0);
        end
        captureFrame(data, ws, uf);
        checkOutput("drain_underflow", uf, 32'd1);

        // Five back-to-back pushes inside a frame: the fifth is dropped.
        target = nextStart(n) + 1;
        while (n < target) tick();
        applyStimulus(10'h3FF, 10'h155);
        applyStimulus(10'h011, 10'h022);
        applyStimulus(10'h033, 10'h044);
        applyStimulus(10'h055, 10'h066);
        checkOutput("ovf4_full", {31'd0, fifoFull}, 32'd1);
        checkOutput("ovf4_overflow", {31'd0, overflow}, 32'd0);
        applyStimulus(10'h077, 10'h088);
        checkOutput("ovf5_full", {31'd0, fifoFull}, 32'd1);
        checkOutput("ovf5_overflow", {31'd0, overflow}, 32'd1);
        captureFrame(data, ws, uf);
        checkOutput("ovf_frame_data", data, 32'hFFC0_5540);
        checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Capture ended in the right slot with three pairs queued; reset for one clk
        // while in_valid is held high.
        inLeft  = 10'h3FF;
        inRight = 10'h3FF;
        inValid = 1'b1;
        doReset(1);
        inValid = 1'b0;
        checkResetState("midreset");
        captureFrame(data, ws, uf);
        checkOutput("postreset_data", data, 32'h0);
        checkOutput("postreset_lrck", ws, 32'h0001_FFFE);
        checkOutput("postreset_underflow", uf, 32'd1);

        checkOutput("bclk_waveform_errors", bclkErr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
